// File: rtl/sevenseg_pkg.sv
// Shared glyph constants and the hex-to-segment lookup for the 7-segment display driver.
// Glyphs are active-low, ordered {a,b,c,d,e,f,g}.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational nibble-to-glyph decoder, shared by all digits of the multiplexed display.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned shadow update,
// per-digit blanking, leading-zero suppression, decimal points and anti-ghost dead time.
module sevenseg_mux_driver
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_blank_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  load_pending,
    output logic                  frame_done
);

    localparam int PREW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PREW-1:0] PRE_LAST = PREW'(REFRESH_DIV - 1);
    localparam logic [PREW-1:0] DEAD_END = PREW'(DEAD_CYCLES);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

    logic [PREW-1:0]     prescaler_q, prescaler_d;
    logic [IDXW-1:0]     digitIdx_q, digitIdx_d;
    logic [4*DIGITS-1:0] shadowData_q, shadowData_d, dispData_q, dispData_d;
    logic [DIGITS-1:0]   shadowDp_q, shadowDp_d, dispDp_q, dispDp_d;
    logic [DIGITS-1:0]   shadowBlank_q, shadowBlank_d, dispBlank_q, dispBlank_d;
    logic                dispValid_q, dispValid_d;
    logic                pending_q, pending_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frameDone_q;
    logic                boundary;
    logic [3:0]          nibbles [DIGITS];
    logic [DIGITS-1:0]   lzMask;
    logic                zeroRun;
    logic [3:0]          selNibble;
    logic [6:0]          glyph;
    logic                digitDark;

    always_comb begin
        boundary      = (prescaler_q == PRE_LAST) && (digitIdx_q == IDX_LAST);
        prescaler_d   = prescaler_q + PREW'(1);
        digitIdx_d    = digitIdx_q;
        if (prescaler_q == PRE_LAST) begin
            prescaler_d = '0;
            digitIdx_d  = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + IDXW'(1);
        end

        shadowData_d  = load ? load_data : shadowData_q;
        shadowDp_d    = load ? dp_in     : shadowDp_q;
        shadowBlank_d = load ? blank_in  : shadowBlank_q;
        dispData_d    = dispData_q;
        dispDp_d      = dispDp_q;
        dispBlank_d   = dispBlank_q;
        dispValid_d   = dispValid_q;
        pending_d     = pending_q;
        // A load landing on the boundary bypasses the shadow so it is never a frame late.
        if (boundary) begin
            dispData_d  = load ? load_data : shadowData_q;
            dispDp_d    = load ? dp_in     : shadowDp_q;
            dispBlank_d = load ? blank_in  : shadowBlank_q;
            dispValid_d = dispValid_q | load | pending_q;
            pending_d   = 1'b0;
        end else if (load) begin
            pending_d   = 1'b1;
        end
    end

    always_comb begin
        zeroRun = 1'b1;
        lzMask  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nibbles[i] = dispData_q[4*i +: 4];
            zeroRun    = zeroRun & (nibbles[i] == 4'h0);
            lzMask[i]  = zeroRun & (i != 0);
        end
    end

    assign selNibble = nibbles[digitIdx_q];
    assign digitDark = dispBlank_q[digitIdx_q] | (lz_blank_en & lzMask[digitIdx_q]);

    sevenseg_decoder u_decoder (
        .nibble_i (selNibble),
        .seg_o    (glyph)
    );

    // Anodes stay off until the first loaded frame commits, and during each slot's dead time.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (dispValid_q && (prescaler_q >= DEAD_END)) begin
            an_d = ~(DIGITS'(1) << digitIdx_q);
            if (!digitDark) begin
                seg_d = glyph;
                dp_d  = ~dispDp_q[digitIdx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q   <= '0;
            digitIdx_q    <= '0;
            shadowData_q  <= '0;
            shadowDp_q    <= '0;
            shadowBlank_q <= '1;
            dispData_q    <= '0;
            dispDp_q      <= '0;
            dispBlank_q   <= '1;
            dispValid_q   <= 1'b0;
            pending_q     <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frameDone_q   <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            digitIdx_q    <= digitIdx_d;
            shadowData_q  <= shadowData_d;
            shadowDp_q    <= shadowDp_d;
            shadowBlank_q <= shadowBlank_d;
            dispData_q    <= dispData_d;
            dispDp_q      <= dispDp_d;
            dispBlank_q   <= dispBlank_d;
            dispValid_q   <= dispValid_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frameDone_q   <= boundary;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign an           = an_q;
    assign load_pending = pending_q;
    assign frame_done   = frameDone_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Self-checking bench for sevenseg_mux_driver: fixed display vectors, hand-built frame-boundary
// sequences and randomized traffic compared against a frame-position reference model.
module tb_sevenseg_mux_driver;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int DEAD_CYCLES = 1;
    localparam int FRAME       = DIGITS * REFRESH_DIV;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dpIn;
        logic [3:0]      blankIn;
        logic            lz;
        logic [3:0][6:0] segExp;
        logic [3:0]      dpExp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, load, lzBlankEn;
    logic [15:0] loadData;
    logic [3:0]  dpIn, blankIn;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        loadPending, frameDone;

    int checks = 0;
    int fails  = 0;

    // Reference model: position within the frame plus shadow/display contents.
    int          mPos = 0;
    logic [15:0] mShData = '0, mDispData = '0;
    logic [3:0]  mShDp = '0, mDispDp = '0, mShBlank = '1, mDispBlank = '1;
    logic        mPending = 1'b0, mValid = 1'b0;
    logic [6:0]  expSeg;
    logic        expDp, expLp, expFd;
    logic [3:0]  expAn;

    vec_t vecs [6];

    sevenseg_mux_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_data    (loadData),
        .dp_in        (dpIn),
        .blank_in     (blankIn),
        .lz_blank_en  (lzBlankEn),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .load_pending (loadPending),
        .frame_done   (frameDone)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", what, act, req, $time);
        end
    endtask

    task automatic modelStep();
        int         slot, phase;
        logic       dark;
        logic [3:0] nib;
        if (reset) begin
            expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expLp = 1'b0; expFd = 1'b0;
            mPos = 0; mShData = '0; mDispData = '0; mShDp = '0; mDispDp = '0;
            mShBlank = '1; mDispBlank = '1; mPending = 1'b0; mValid = 1'b0;
            return;
        end
        slot  = mPos / REFRESH_DIV;
        phase = mPos % REFRESH_DIV;
        expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1;
        if (mValid && phase >= DEAD_CYCLES) begin
            expAn = ~(4'b0001 << slot);
            nib   = mDispData[4*slot +: 4];
            dark  = mDispBlank[slot] || (lzBlankEn && slot != 0 && (mDispData >> (4*slot)) == 16'h0);
            if (!dark) begin
                expSeg = GLYPH[nib];
                expDp  = ~mDispDp[slot];
            end
        end
        expFd = (mPos == FRAME - 1);
        if (mPos == FRAME - 1) begin
            if (load) begin
                mDispData = loadData; mDispDp = dpIn; mDispBlank = blankIn;
            end else begin
                mDispData = mShData; mDispDp = mShDp; mDispBlank = mShBlank;
            end
            if (load || mPending) mValid = 1'b1;
            mPending = 1'b0;
        end else if (load) begin
            mPending = 1'b1;
        end
        if (load) begin
            mShData = loadData; mShDp = dpIn; mShBlank = blankIn;
        end
        expLp = mPending;
        mPos  = (mPos + 1) % FRAME;
    endtask

    task automatic checkOutput();
        checkVal("model.an",   an,          expAn);
        checkVal("model.seg",  seg,         expSeg);
        checkVal("model.dp",   dp,          expDp);
        checkVal("model.lp",   loadPending, expLp);
        checkVal("model.fd",   frameDone,   expFd);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic waitFrameDone(input string what);
        int k = 0;
        while (frameDone !== 1'b1 && k < 3 * FRAME) begin
            tick();
            k++;
        end
        checkVal(what, frameDone, 1);
    endtask

    task automatic waitPos(input int target);
        int k = 0;
        while (mPos != target && k < FRAME) begin
            tick();
            k++;
        end
    endtask

    task automatic loadOnce(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        loadData = d; dpIn = p; blankIn = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [3:0] anReq;
        int         slot;
        lzBlankEn = v.lz;
        loadOnce(v.data, v.dpIn, v.blankIn);
        waitFrameDone("tbl.commit");
        for (int j = 0; j < FRAME; j++) begin
            tick();
            slot  = j / REFRESH_DIV;
            anReq = ~(4'b0001 << slot);
            if (j % REFRESH_DIV < DEAD_CYCLES) begin
                checkVal("tbl.deadAn",  an,  4'hF);
                checkVal("tbl.deadSeg", seg, 7'h7F);
            end else begin
                checkVal("tbl.an",  an,  anReq);
                checkVal("tbl.seg", seg, v.segExp[slot]);
                checkVal("tbl.dp",  dp,  v.dpExp[slot]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0][6:0] seq4321;
        logic [3:0]      anReq;
        int              fdCount;

        vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1111};
        vecs[1] = '{16'h0050, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h0050, 4'h0, 4'h0, 1'b0, {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b1111};
        vecs[3] = '{16'h0000, 4'b0100, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1111};
        vecs[4] = '{16'h8E3C, 4'b0101, 4'b0010, 1'b1, {7'b0000000, 7'b0110000, 7'h7F, 7'b0110001}, 4'b1010};
        vecs[5] = '{16'h0900, 4'b0001, 4'b1000, 1'b1, {7'h7F, 7'b0000100, 7'b0000001, 7'b0000001}, 4'b1110};

        reset = 1'b1; load = 1'b0; loadData = '0; dpIn = '0; blankIn = '0; lzBlankEn = 1'b0;
        tick();
        tick();
        checkVal("rst.an",  an,          4'hF);
        checkVal("rst.seg", seg,         7'h7F);
        checkVal("rst.dp",  dp,          1'b1);
        checkVal("rst.lp",  loadPending, 1'b0);
        checkVal("rst.fd",  frameDone,   1'b0);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            checkVal("idle.an",  an,          4'hF);
            checkVal("idle.seg", seg,         7'h7F);
            checkVal("idle.lp",  loadPending, 1'b0);
        end

        $display("[TB] table-driven display vectors");
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        $display("[TB] last load before the boundary wins");
        lzBlankEn = 1'b0;
        waitFrameDone("lw.align");
        tick();
        tick();
        loadOnce(16'h1111, 4'h0, 4'h0);
        checkVal("lw.lpFirst", loadPending, 1'b1);
        tick();
        tick();
        loadOnce(16'h2222, 4'h0, 4'h0);
        checkVal("lw.lpSecond", loadPending, 1'b1);
        waitFrameDone("lw.commit");
        checkVal("lw.lpCleared", loadPending, 1'b0);
        for (int j = 0; j < FRAME; j++) begin
            tick();
            if (j % REFRESH_DIV >= DEAD_CYCLES) checkVal("lw.seg", seg, 7'b0010010);
        end

        $display("[TB] load on the boundary cycle");
        seq4321 = {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        waitPos(FRAME - 1);
        loadOnce(16'h4321, 4'h0, 4'h0);
        checkVal("bnd.fd", frameDone,   1'b1);
        checkVal("bnd.lp", loadPending, 1'b0);
        for (int j = 0; j < FRAME; j++) begin
            tick();
            anReq = ~(4'b0001 << (j / REFRESH_DIV));
            if (j % REFRESH_DIV >= DEAD_CYCLES) begin
                checkVal("bnd.an",  an,  anReq);
                checkVal("bnd.seg", seg, seq4321[j / REFRESH_DIV]);
            end
        end
        fdCount = 0;
        for (int j = 0; j < 4 * FRAME; j++) begin
            tick();
            if (frameDone === 1'b1) fdCount++;
        end
        checkVal("bnd.fdCount", fdCount, 4);

        $display("[TB] reset mid-slot with a pending load");
        waitPos(6);
        loadOnce(16'h9999, 4'hF, 4'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkVal("mrst.an",  an,          4'hF);
        checkVal("mrst.seg", seg,         7'h7F);
        checkVal("mrst.lp",  loadPending, 1'b0);
        for (int j = 0; j < 3 * FRAME; j++) begin
            tick();
            checkVal("mrst.darkAn",  an,  4'hF);
            checkVal("mrst.darkSeg", seg, 7'h7F);
        end

        $display("[TB] randomized traffic against the reference model");
        for (int i = 0; i < 800; i++) begin
            load      = ($urandom_range(0, 7) == 0);
            loadData  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dpIn      = 4'($urandom);
            blankIn   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 40) == 0) lzBlankEn = ~lzBlankEn;
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        load = 1'b0;
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
